// File: rtl/alu_pkg.sv
// Shared ALU op encodings, buffer occupancy states and the result-buffer entry layout.
package alu_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_INVALID = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] result;
        logic                 zero;
        logic                 illegal;
        logic [4:0]           rd;
        logic                 reg_write;
    } entry_t;

endpackage

// File: rtl/alu_execute_stage_if.sv
// Operation-in / result-out handshake bundle of the execute stage.
interface alu_execute_stage_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       rd_in;
    logic             reg_write_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             illegal;
    logic [4:0]       rd_out;
    logic             reg_write_out;

    modport master (
        output in_valid, alu_ctrl, operand_a, operand_b, rd_in, reg_write_in, out_ready,
        input  in_ready, out_valid, alu_result, zero, illegal, rd_out, reg_write_out
    );

    modport slave (
        input  in_valid, alu_ctrl, operand_a, operand_b, rd_in, reg_write_in, out_ready,
        output in_ready, out_valid, alu_result, zero, illegal, rd_out, reg_write_out
    );
endinterface

// File: rtl/alu_execute_stage_alu.sv
// Combinational ALU datapath; undefined op codes give a zero result and raise illegal.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    alu_op_e op;
    assign op = alu_op_e'(ctrl);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result[0] = ($signed(a) < $signed(b));
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: computes on accept and holds results in a 2-entry in-order skid buffer.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    input logic                flush,
    alu_execute_stage_if.slave bus
);
    cnt_e             cnt;
    entry_t           slot0;
    entry_t           slot1;
    entry_t           new_e;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             pop;

    alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl    (bus.alu_ctrl),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .result  (alu_res),
        .illegal (alu_ill)
    );

    always_comb begin
        new_e           = '0;
        new_e.result    = MAX_WIDTH'(alu_res);
        new_e.zero      = (alu_res == '0);
        new_e.illegal   = alu_ill;
        new_e.rd        = bus.rd_in;
        new_e.reg_write = bus.reg_write_in & ~alu_ill;
    end

    assign in_ready  = ({30'd0, cnt} < DEPTH);
    assign out_valid = (cnt != CNT_EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // slot0 is always the head; in ONE an accept+pop overwrites it in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= CNT_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            cnt <= CNT_EMPTY;
        end else begin
            case (cnt)
                CNT_EMPTY: begin
                    if (accept) begin
                        slot0 <= new_e;
                        cnt   <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (accept && pop) begin
                        slot0 <= new_e;
                    end else if (accept) begin
                        slot1 <= new_e;
                        cnt   <= CNT_FULL;
                    end else if (pop) begin
                        cnt <= CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        slot0 <= slot1;
                        cnt   <= CNT_ONE;
                    end
                end
                default: cnt <= CNT_EMPTY;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.alu_result    = out_valid ? slot0.result[WIDTH-1:0] : '0;
    assign bus.zero          = out_valid & slot0.zero;
    assign bus.illegal       = out_valid & slot0.illegal;
    assign bus.rd_out        = out_valid ? slot0.rd : 5'd0;
    assign bus.reg_write_out = out_valid & slot0.reg_write;
endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: op table, backpressure/flush/reset sequences, random traffic vs a queue model.
module tb_alu_execute_stage;

    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic        illegal;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] res;
        logic        z;
        logic        il;
        logic        rwo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    alu_execute_stage_if #(.WIDTH(64)) bus ();

    alu_execute_stage #(.WIDTH(64), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                       input logic [4:0] rd, input logic rw);
        exp_t e;
        longint sa, sb;
        sa = a;
        sb = b;
        e.illegal = 1'b0;
        case (c)
            4'd0:    e.result = a & b;
            4'd1:    e.result = a | b;
            4'd2:    e.result = a + b;
            4'd6:    e.result = a - b;
            4'd7:    e.result = (sa < sb) ? 64'd1 : 64'd0;
            default: begin e.result = 64'd0; e.illegal = 1'b1; end
        endcase
        e.zero = (e.result == 64'd0);
        e.rd   = rd;
        e.rw   = rw && !e.illegal;
        return e;
    endfunction

    task automatic set_op(input logic v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic rw);
        bus.in_valid     = v;
        bus.alu_ctrl     = c;
        bus.operand_a    = a;
        bus.operand_b    = b;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
    endtask

    // One clock: compare outputs with the model head, then advance the model at the edge.
    task automatic cyc();
        int   n;
        exp_t h;
        exp_t e;
        logic acc, pp;
        #1;
        n = q.size();
        h = (n > 0) ? q[0] : '0;
        chk("in_ready", bus.in_ready, n < 2);
        chk("out_valid", bus.out_valid, n > 0);
        chk("alu_result", bus.alu_result, h.result);
        chk("zero", bus.zero, h.zero);
        chk("illegal", bus.illegal, h.illegal);
        chk("rd_out", bus.rd_out, h.rd);
        chk("reg_write_out", bus.reg_write_out, h.rw);
        acc = bus.in_valid && (n < 2);
        pp  = (n > 0) && bus.out_ready;
        e   = ref_model(bus.alu_ctrl, bus.operand_a, bus.operand_b, bus.rd_in, bus.reg_write_in);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'h2, 64'd5, 64'd7, 5'd1, 1'b1, 64'd12, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'h6, 64'd3, 64'd3, 5'd2, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{4'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 1'b1, 64'd1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'hF, 64'd9, 64'd4, 5'd4, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{4'h0, 64'hF0F0, 64'h0FF0, 5'd5, 1'b1, 64'h00F0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'h1, 64'hF0F0, 64'h0F0F, 5'd6, 1'b0, 64'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 1'b1, 64'd1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'h6, 64'd0, 64'd1, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'h7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{4'h7, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 5'd10, 1'b1, 64'd1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4'h3, 64'd1, 64'd1, 5'd11, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{4'h5, 64'd7, 64'd7, 5'd31, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        set_op(1'b0, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0);
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.alu_result, 64'd0);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);
        chk("rst_rd", bus.rd_out, 5'd0);
        chk("rst_rw", bus.reg_write_out, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_in_ready", bus.in_ready, 1'b1);

        // Single-op table, one accept then one drain per entry
        for (int i = 0; i < 12; i++) begin
            set_op(1'b1, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].rw);
            bus.out_ready = 1'b1;
            #1 chk("tbl_in_ready", bus.in_ready, 1'b1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            #1;
            chk("tbl_valid", bus.out_valid, 1'b1);
            chk("tbl_result", bus.alu_result, tbl[i].res);
            chk("tbl_zero", bus.zero, tbl[i].z);
            chk("tbl_illegal", bus.illegal, tbl[i].il);
            chk("tbl_rd", bus.rd_out, tbl[i].rd);
            chk("tbl_rw", bus.reg_write_out, tbl[i].rwo);
            @(posedge clk);
            #1;
            chk("tbl_drain_valid", bus.out_valid, 1'b0);
            chk("tbl_drain_result", bus.alu_result, 64'd0);
        end

        // Backpressure: third op held while full, then in-order delivery
        bus.out_ready = 1'b0;
        set_op(1'b1, 4'h2, 64'd10, 64'd20, 5'd1, 1'b1); cyc();
        set_op(1'b1, 4'h6, 64'd100, 64'd1, 5'd2, 1'b1); cyc();
        set_op(1'b1, 4'h1, 64'h30, 64'h03, 5'd3, 1'b1);
        #1;
        chk("bp_full_ready", bus.in_ready, 1'b0);
        chk("bp_head", bus.alu_result, 64'd30);
        cyc();
        cyc();
        #1;
        chk("bp_stable", bus.alu_result, 64'd30);
        chk("bp_stable_rd", bus.rd_out, 5'd1);
        bus.out_ready = 1'b1;
        cyc();
        #1;
        chk("bp_second", bus.alu_result, 64'd99);
        chk("bp_ready_after_pop", bus.in_ready, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("bp_third", bus.alu_result, 64'h33);
        chk("bp_third_rd", bus.rd_out, 5'd3);
        cyc();
        cyc();

        // Flush while full with a new op offered
        bus.out_ready = 1'b0;
        set_op(1'b1, 4'h2, 64'd4, 64'd4, 5'd12, 1'b1); cyc();
        set_op(1'b1, 4'h2, 64'd6, 64'd6, 5'd13, 1'b1); cyc();
        set_op(1'b1, 4'h2, 64'd1, 64'd2, 5'd14, 1'b1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_ready", bus.in_ready, 1'b1);
        cyc();
        #1 chk("flush_nocap", bus.out_valid, 1'b0);

        // Asynchronous reset mid-cycle while full
        bus.out_ready = 1'b0;
        set_op(1'b1, 4'h2, 64'd8, 64'd8, 5'd15, 1'b1); cyc();
        set_op(1'b1, 4'h2, 64'd9, 64'd9, 5'd16, 1'b1); cyc();
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_result", bus.alu_result, 64'd0);
        chk("async_rst_rw", bus.reg_write_out, 1'b0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        set_op(1'b1, 4'h2, 64'd1, 64'd1, 5'd17, 1'b1);
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        #1 chk("post_rst_add", bus.alu_result, 64'd2);
        cyc();

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  c;
            logic [63:0] a, b;
            case ($urandom_range(0, 7))
                0: c = 4'h0;
                1: c = 4'h1;
                2: c = 4'h2;
                3: c = 4'h6;
                4: c = 4'h7;
                5: c = 4'($urandom);
                6: c = 4'hF;
                default: c = 4'h2;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            set_op(($urandom_range(0, 9) < 7), c, a, b, 5'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 19) == 0);
            cyc();
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
ALU_EXECUTE_STAGE -- requirements
Module: alu_execute_stage

Interface
REQ-001: Parameter WIDTH, default 64, SHALL set the datapath width in bits.
REQ-002: Parameter DEPTH, fixed at 2, SHALL set the result-buffer entry count (skid buffer).
REQ-003: Clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004: Reset  input  1  SHALL be asynchronous, active-high.
REQ-005: Flush  input  1  SHALL be a synchronous discard of all buffered results.
REQ-006: In_Valid  input  1  SHALL mark that the upstream operation is valid.
REQ-007: In_Ready  output  1  SHALL mark that the stage accepts an operation this cycle.
REQ-008: ALU_Ctrl  input  4  SHALL carry the op code from the ALU control decoder.
REQ-009: Operand_A, Operand_B  input  WIDTH  SHALL carry the source operands.
REQ-010: Rd_In  input  5  SHALL carry the destination register tag; Reg_Write_In  input  1  SHALL carry the write enable.
REQ-011: Out_Valid  output  1  SHALL mark that the head result is valid; Out_Ready  input  1  SHALL mark downstream acceptance.
REQ-012: ALU_Result  output  WIDTH  SHALL carry the result; Zero  output  1  SHALL be result==0; Illegal  output  1  SHALL flag an undefined op.
REQ-013: Rd_Out  output  5 and Reg_Write_Out  output  1  SHALL carry the head entry's tag and write enable.

Function
REQ-014: Accept SHALL occur when In_Valid && In_Ready; pop SHALL occur when Out_Valid && Out_Ready.
REQ-015: In_Ready SHALL be 1 iff fewer than 2 entries are buffered; it SHALL be combinational from the count only, not from Out_Ready.
REQ-016: The ALU SHALL compute combinationally on accepted inputs; the result SHALL be written into the buffer at the accepting edge; Out_Valid SHALL rise the cycle after acceptance (latency 1).
REQ-017: ALU_Ctrl 0000 SHALL yield A AND B; 0001 SHALL yield A OR B; 0010 SHALL yield A+B mod 2^WIDTH; 0110 SHALL yield A-B mod 2^WIDTH.
REQ-018: ALU_Ctrl 0111 (SLT) SHALL yield 1 if signed A < signed B, else 0, zero-extended to WIDTH.
REQ-019: Any other ALU_Ctrl (including 1111) SHALL store result 0, Illegal=1, and Reg_Write_Out=0 for that entry.
REQ-020: Zero SHALL be computed from the stored result, so illegal entries report Zero=1.
REQ-021: The buffer SHALL be in-order (FIFO); outputs SHALL present the oldest entry and SHALL hold stable while Out_Valid && !Out_Ready.
REQ-022: Count states EMPTY(0), ONE(1), FULL(2): accept-only increments, pop-only decrements, accept+pop holds; in ONE, a simultaneous accept and pop SHALL replace the head with the new entry.
REQ-023: In FULL, a pop SHALL make In_Ready high only in the next cycle.
REQ-024: Flush SHALL override accept and pop in the same cycle: count becomes 0, nothing is written, and Out_Valid=0 next cycle.
REQ-025: Outputs SHALL be 0 whenever Out_Valid=0.

Reset
REQ-026: Reset SHALL clear the count to EMPTY immediately, regardless of the clock; Out_Valid=0, ALU_Result=0, Zero=0, Illegal=0, Rd_Out=0, Reg_Write_Out=0.
REQ-027: In_Ready SHALL be 1 from the first edge after Reset deasserts; entries in flight at reset SHALL be lost.

Structure
REQ-028: A shared package alu_pkg SHALL hold the ALU_Ctrl encodings (AND, OR, ADD, SUB, SLT, INVALID) as a 4-bit enum and the buffer-entry struct {result, zero, illegal, rd, reg_write}.
REQ-029: The combinational datapath SHALL be a sub-module named alu; the buffer and handshake logic SHALL live in alu_execute_stage.

Verification
REQ-030: ADD A=5, B=7, Out_Ready=1 -> next cycle Out_Valid=1, ALU_Result=12, Zero=0, Illegal=0.
REQ-031: SUB A=3, B=3, then SLT A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> results 0 (Zero=1), then 1.
REQ-032: Out_Ready=0 with 3 back-to-back ops -> In_Ready=0 after 2 accepts, third held, outputs stable; release -> in-order delivery.
REQ-033: ALU_Ctrl=1111, Reg_Write_In=1 -> ALU_Result=0, Illegal=1, Zero=1, Reg_Write_Out=0.
REQ-034: FULL with Flush and In_Valid asserted together -> next cycle Out_Valid=0, count=0, new op not captured.
REQ-035: Reset asserted mid-cycle while FULL -> Out_Valid=0 before the next edge; a following ADD 1+1 -> 2 after one cycle.
